// File: rtl/alarm_buzzer_seq.sv
// Alarm buzzer sequencer: turns the GPIO alarm level into bursts of square-wave
// beeps separated by a pause, with a snooze button that silences it for a while.
module alarm_buzzer_seq #(
   parameter int TONE_HALF_CYCLES = 12500,
   parameter int BEEP_ON_CYCLES   = 5000000,
   parameter int BEEP_OFF_CYCLES  = 5000000,
   parameter int BEEPS_PER_BURST  = 4,
   parameter int PAUSE_CYCLES     = 30000000,
   parameter int SNOOZE_CYCLES    = 500000000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic snooze,
   output logic buzzer_out,
   output logic active,
   output logic snoozing
);

   localparam int MAX_A     = (BEEP_ON_CYCLES > BEEP_OFF_CYCLES) ? BEEP_ON_CYCLES : BEEP_OFF_CYCLES;
   localparam int MAX_B     = (PAUSE_CYCLES > SNOOZE_CYCLES) ? PAUSE_CYCLES : SNOOZE_CYCLES;
   localparam int MAX_PHASE = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int PW        = $clog2(MAX_PHASE) + 1;
   localparam int TW        = $clog2(TONE_HALF_CYCLES) + 1;
   localparam int BW        = $clog2(BEEPS_PER_BURST) + 1;

   localparam logic [PW-1:0] ON_LAST     = PW'(BEEP_ON_CYCLES - 1);
   localparam logic [PW-1:0] OFF_LAST    = PW'(BEEP_OFF_CYCLES - 1);
   localparam logic [PW-1:0] PAUSE_LAST  = PW'(PAUSE_CYCLES - 1);
   localparam logic [PW-1:0] SNOOZE_LAST = PW'(SNOOZE_CYCLES - 1);
   localparam logic [TW-1:0] HALF_LAST   = TW'(TONE_HALF_CYCLES - 1);
   localparam logic [BW-1:0] BEEP_LAST   = BW'(BEEPS_PER_BURST - 1);

   typedef enum logic [2:0] {IDLE, TONE, GAP, PAUSE, SNOOZE} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] phase_cnt, phase_nxt;
   logic [TW-1:0] tone_cnt, tone_nxt;
   logic [BW-1:0] beep_idx, beep_nxt;
   logic          buzzer_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         phase_cnt  <= '0;
         tone_cnt   <= '0;
         beep_idx   <= '0;
         buzzer_out <= 1'b0;
         active     <= 1'b0;
         snoozing   <= 1'b0;
      end else begin
         state      <= state_nxt;
         phase_cnt  <= phase_nxt;
         tone_cnt   <= tone_nxt;
         beep_idx   <= beep_nxt;
         buzzer_out <= buzzer_nxt;
         active     <= (state_nxt != IDLE);
         snoozing   <= (state_nxt == SNOOZE);
      end
   end

   // Dropping enable beats snooze, and snooze beats any timer expiry.
   always_comb begin
      state_nxt = state;
      beep_nxt  = beep_idx;
      if (state != IDLE && !enable) begin
         state_nxt = IDLE;
         beep_nxt  = '0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  state_nxt = TONE;
                  beep_nxt  = '0;
               end
            end
            TONE: begin
               if (snooze) begin
                  state_nxt = SNOOZE;
               end else if (phase_cnt == ON_LAST) begin
                  if (beep_idx == BEEP_LAST) begin
                     state_nxt = PAUSE;
                  end else begin
                     state_nxt = GAP;
                     beep_nxt  = beep_idx + 1'b1;
                  end
               end
            end
            GAP: begin
               if (snooze) begin
                  state_nxt = SNOOZE;
               end else if (phase_cnt == OFF_LAST) begin
                  state_nxt = TONE;
               end
            end
            PAUSE: begin
               if (snooze) begin
                  state_nxt = SNOOZE;
               end else if (phase_cnt == PAUSE_LAST) begin
                  state_nxt = TONE;
                  beep_nxt  = '0;
               end
            end
            SNOOZE: begin
               if (phase_cnt == SNOOZE_LAST) begin
                  state_nxt = TONE;
                  beep_nxt  = '0;
               end
            end
            default: begin
               state_nxt = IDLE;
               beep_nxt  = '0;
            end
         endcase
      end
   end

   // Every TONE entry restarts the tone phase high; any other state is silent.
   always_comb begin
      phase_nxt  = '0;
      tone_nxt   = '0;
      buzzer_nxt = 1'b0;
      if (state_nxt == state && state_nxt != IDLE) begin
         phase_nxt = phase_cnt + 1'b1;
      end
      if (state_nxt == TONE) begin
         if (state != TONE) begin
            buzzer_nxt = 1'b1;
         end else if (tone_cnt == HALF_LAST) begin
            buzzer_nxt = ~buzzer_out;
         end else begin
            buzzer_nxt = buzzer_out;
            tone_nxt   = tone_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alarm_buzzer_seq.sv
// Self-checking bench for alarm_buzzer_seq: vector table, hand-written corner
// sequences and a randomized run, all checked against a burst-timeline model.
module tb_alarm_buzzer_seq;

   localparam int HALF   = 2;
   localparam int ON     = 8;
   localparam int OFF    = 4;
   localparam int BEEPS  = 2;
   localparam int PAUSE  = 6;
   localparam int SNZ    = 10;
   localparam int PERIOD = BEEPS * ON + (BEEPS - 1) * OFF + PAUSE;

   logic clk = 1'b0;
   logic reset, enable, snooze;
   logic buzzer_out, active, snoozing;

   int compared   = 0;
   int mismatched = 0;

   // 0 = idle, 1 = running the burst timeline, 2 = snoozed
   int m_mode = 0;
   int m_t    = 0;
   int m_sn   = 0;

   typedef struct {
      logic rst;
      logic en;
      logic sn;
      logic buz;
      logic act;
      logic snz;
   } vec_t;

   vec_t vecs[17];

   alarm_buzzer_seq #(
      .TONE_HALF_CYCLES(HALF),
      .BEEP_ON_CYCLES  (ON),
      .BEEP_OFF_CYCLES (OFF),
      .BEEPS_PER_BURST (BEEPS),
      .PAUSE_CYCLES    (PAUSE),
      .SNOOZE_CYCLES   (SNZ)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .snooze    (snooze),
      .buzzer_out(buzzer_out),
      .active    (active),
      .snoozing  (snoozing)
   );

   always #5 clk = ~clk;

   // Expected buzzer level from the position inside the repeating burst.
   function automatic logic model_buzzer();
      int k, o;
      if (m_mode != 1) return 1'b0;
      k = m_t / (ON + OFF);
      o = m_t % (ON + OFF);
      if (k < BEEPS && o < ON) return ((o / HALF) % 2) == 0;
      return 1'b0;
   endfunction

   task automatic model_step(input logic r, input logic e, input logic s);
      if (r || !e) begin
         m_mode = 0;
      end else if (m_mode == 0) begin
         m_mode = 1;
         m_t    = 0;
      end else if (m_mode == 1) begin
         if (s) begin
            m_mode = 2;
            m_sn   = 0;
         end else begin
            m_t = (m_t + 1) % PERIOD;
         end
      end else begin
         if (m_sn == SNZ - 1) begin
            m_mode = 1;
            m_t    = 0;
         end else begin
            m_sn = m_sn + 1;
         end
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic s);
      reset  = r;
      enable = e;
      snooze = s;
      @(posedge clk);
      model_step(r, e, s);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic eb, input logic ea, input logic es);
      compared++;
      if (buzzer_out !== eb || active !== ea || snoozing !== es) begin
         mismatched++;
         $display("[TB] FAIL %s: got buzzer_out=%b active=%b snoozing=%b, expected %b %b %b",
                  name, buzzer_out, active, snoozing, eb, ea, es);
      end
   endtask

   task automatic checkModel(input string name);
      checkOutput(name, model_buzzer(), m_mode != 0, m_mode == 2);
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      snooze = 1'b0;

      vecs[0]  = '{1, 1, 0, 0, 0, 0};
      vecs[1]  = '{1, 1, 0, 0, 0, 0};
      vecs[2]  = '{1, 1, 0, 0, 0, 0};
      vecs[3]  = '{0, 1, 0, 1, 1, 0};
      vecs[4]  = '{0, 1, 0, 1, 1, 0};
      vecs[5]  = '{0, 1, 0, 0, 1, 0};
      vecs[6]  = '{0, 1, 0, 0, 1, 0};
      vecs[7]  = '{0, 1, 0, 1, 1, 0};
      vecs[8]  = '{0, 1, 0, 1, 1, 0};
      vecs[9]  = '{0, 1, 0, 0, 1, 0};
      vecs[10] = '{0, 1, 0, 0, 1, 0};
      vecs[11] = '{0, 1, 0, 0, 1, 0};
      vecs[12] = '{0, 1, 1, 0, 1, 1};
      vecs[13] = '{0, 0, 1, 0, 0, 0};
      vecs[14] = '{0, 0, 1, 0, 0, 0};
      vecs[15] = '{0, 1, 0, 1, 1, 0};
      vecs[16] = '{0, 0, 1, 0, 0, 0};

      $display("[TB] vector table");
      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].sn);
         checkOutput($sformatf("vec%0d", i), vecs[i].buz, vecs[i].act, vecs[i].snz);
         checkModel($sformatf("vec%0d_model", i));
      end

      $display("[TB] continuous burst and mid-tone enable drop");
      applyStimulus(1, 0, 0);
      checkOutput("drop_reset", 0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("drop_start", 1, 1, 0);
      for (int k = 1; k < 5; k++) begin
         applyStimulus(0, 1, 0);
         checkModel("drop_tone");
      end
      applyStimulus(0, 0, 0);
      checkOutput("drop_idle", 0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput("drop_restart", 1, 1, 0);
      for (int k = 1; k < 60; k++) begin
         applyStimulus(0, 1, 0);
         checkModel("burst_run");
         if (k == 8)  checkOutput("burst_gap",        0, 1, 0);
         if (k == 12) checkOutput("burst_beep2",      1, 1, 0);
         if (k == 20) checkOutput("burst_pause",      0, 1, 0);
         if (k == 25) checkOutput("burst_pause_end",  0, 1, 0);
         if (k == 26) checkOutput("burst_period_26",  1, 1, 0);
      end

      $display("[TB] snooze during gap");
      applyStimulus(1, 0, 0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(0, 1, 0);
         checkModel("gap_lead");
      end
      applyStimulus(0, 1, 1);
      checkOutput("snz_enter", 0, 1, 1);
      for (int j = 1; j < 10; j++) begin
         applyStimulus(0, 1, j == 4);
         checkOutput($sformatf("snz_hold%0d", j), 0, 1, 1);
      end
      applyStimulus(0, 1, 0);
      checkOutput("snz_exit", 1, 1, 0);
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(0, 1, 0);
         checkModel("snz_after");
         if (k == 8)  checkOutput("snz_after_gap",   0, 1, 0);
         if (k == 12) checkOutput("snz_after_beep1", 1, 1, 0);
      end

      $display("[TB] snooze on last-beep expiry");
      applyStimulus(1, 0, 0);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(0, 1, 0);
         checkModel("last_lead");
      end
      applyStimulus(0, 1, 1);
      checkOutput("last_snz_enter", 0, 1, 1);
      for (int j = 1; j < 10; j++) begin
         applyStimulus(0, 1, 0);
         checkModel("last_snz_hold");
      end
      applyStimulus(0, 1, 0);
      checkOutput("last_snz_exit", 1, 1, 0);
      applyStimulus(0, 0, 0);
      checkOutput("last_idle", 0, 0, 0);
      applyStimulus(0, 0, 1);
      checkOutput("idle_snooze_ignored", 0, 0, 0);

      $display("[TB] randomized run");
      for (int n = 0; n < 3000; n++) begin
         logic r, e, s;
         r = ($urandom_range(0, 199) == 0);
         e = ($urandom_range(0, 49) != 0);
         s = ($urandom_range(0, 29) == 0);
         applyStimulus(r, e, s);
         checkModel($sformatf("rand%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
